// File: rtl/aes_pkg.sv
// +-----------------------------------------------------------------+
// | aes_pkg : shared AES datapath constants, FSM encoding, xtime    |
// | Rev 1.0 : initial release                                       |
// +-----------------------------------------------------------------+
`default_nettype none

package aes_pkg;

   localparam logic [7:0] AES_POLY = 8'h1B;
   localparam int         COL_W    = 32;
   localparam int         STATE_W  = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mix_columns_seq_if.sv
// +-----------------------------------------------------------------+
// | mix_columns_seq_if : start/ready handshake and state buses      |
// | Rev 1.0 : initial release                                       |
// +-----------------------------------------------------------------+
`default_nettype none

interface mix_columns_seq_if;
   import aes_pkg::*;

   logic               start;
   logic               bypass;
   logic [STATE_W-1:0] input_s;
   logic [STATE_W-1:0] output_s;
   logic               busy;
   logic               ready;

   modport master (
      output start, bypass, input_s,
      input  output_s, busy, ready
   );

   modport slave (
      input  start, bypass, input_s,
      output output_s, busy, ready
   );
endinterface

`default_nettype wire

// File: rtl/mix_single_column.sv
// +-----------------------------------------------------------------+
// | mix_single_column : combinational forward MixColumns, 1 column  |
// | Rev 1.0 : initial release                                       |
// +-----------------------------------------------------------------+
`default_nettype none

module mix_single_column
   import aes_pkg::*;
(
   input  wire logic [COL_W-1:0] col_in,
   output logic      [COL_W-1:0] col_out
);

   logic [7:0] w_b0, w_b1, w_b2, w_b3;
   logic [7:0] w_x0, w_x1, w_x2, w_x3;

   assign w_b0 = col_in[7:0];
   assign w_b1 = col_in[15:8];
   assign w_b2 = col_in[23:16];
   assign w_b3 = col_in[31:24];

   assign w_x0 = xtime(w_b0);
   assign w_x1 = xtime(w_b1);
   assign w_x2 = xtime(w_b2);
   assign w_x3 = xtime(w_b3);

   // 3*x is expressed as xtime(x) ^ x
   assign col_out[7:0]   = w_x0 ^ (w_x1 ^ w_b1) ^ w_b2 ^ w_b3;
   assign col_out[15:8]  = w_b0 ^ w_x1 ^ (w_x2 ^ w_b2) ^ w_b3;
   assign col_out[23:16] = w_b0 ^ w_b1 ^ w_x2 ^ (w_x3 ^ w_b3);
   assign col_out[31:24] = (w_x0 ^ w_b0) ^ w_b1 ^ w_b2 ^ w_x3;

endmodule

`default_nettype wire

// File: rtl/mix_columns_seq.sv
// +-----------------------------------------------------------------+
// | mix_columns_seq : iterative forward MixColumns, 1 column/clock  |
// | Rev 1.0 : initial release                                       |
// +-----------------------------------------------------------------+
`default_nettype none

module mix_columns_seq
   import aes_pkg::*;
#(
   parameter int NUM_COLS = 4,
   parameter int CNT_W    = 2
)(
   input wire logic          clk,
   input wire logic          rst_n,
   mix_columns_seq_if.slave  bus
);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [STATE_W-1:0] r_copy;
   logic               r_bypass;
   logic [STATE_W-1:0] r_out;
   logic               r_busy;
   logic               r_ready;

   logic [COL_W-1:0]   w_col_sel;
   logic [COL_W-1:0]   w_col_mix;
   logic [COL_W-1:0]   w_col_res;

   assign w_col_sel = r_copy[COL_W*r_cnt +: COL_W];

   mix_single_column u_mix (
      .col_in  (w_col_sel),
      .col_out (w_col_mix)
   );

   assign w_col_res = r_bypass ? w_col_sel : w_col_mix;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_copy   <= '0;
         r_bypass <= 1'b0;
         r_out    <= '0;
         r_busy   <= 1'b0;
         r_ready  <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               r_ready <= 1'b0;
               if (bus.start) begin
                  r_copy   <= bus.input_s;
                  r_bypass <= bus.bypass;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= RUN;
               end else begin
                  r_state  <= IDLE;
               end
            end
            RUN: begin
               // start is deliberately not looked at here: requests while busy are dropped
               r_out[COL_W*r_cnt +: COL_W] <= w_col_res;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(NUM_COLS - 1)) begin
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.output_s = r_out;
   assign bus.busy     = r_busy;
   assign bus.ready    = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq against a GF(2^8) matrix reference model.
`default_nettype none

module tb_mix_columns_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   mix_columns_seq_if bus_if ();

   mix_columns_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   // Reference: generic shift-and-add GF multiply and circulant matrix {2,3,1,1}
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
      end
      return p;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] s, input bit byp);
      logic [7:0]   m [4];
      logic [127:0] o = '0;
      logic [7:0]   acc;
      m[0] = 8'd2; m[1] = 8'd3; m[2] = 8'd1; m[3] = 8'd1;
      if (byp) return s;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gf_mul(m[(j - r + 4) % 4], s[32*c + 8*j +: 8]);
            o[32*c + 8*r +: 8] = acc;
         end
      return o;
   endfunction

   // Launches a block and waits for ready; cyc = clocks from capture edge to ready
   task automatic do_block(input logic [127:0] din, input bit byp,
                           output logic [127:0] dout, output int cyc, output int busy_cnt);
      @(negedge clk);
      bus_if.start = 1'b1; bus_if.bypass = byp; bus_if.input_s = din;
      @(negedge clk);
      bus_if.start = 1'b0;
      cyc = 0; busy_cnt = 0;
      while (!bus_if.ready && cyc < 20) begin
         if (bus_if.busy) busy_cnt++;
         @(negedge clk);
         cyc++;
      end
      dout = bus_if.output_s;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_tests++;
      if (bus_if.output_s !== 128'h0 || bus_if.busy !== 1'b0 || bus_if.ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: out=%h busy=%b ready=%b, required out=0 busy=0 ready=0",
                  bus_if.output_s, bus_if.busy, bus_if.ready);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      logic [127:0] dout; int cyc, bc;
      do_block({4{32'h455313db}}, 1'b0, dout, cyc, bc);
      n_tests++;
      if (cyc !== 4) begin n_fail++; $display("FAIL single_latency: got %0d required 4", cyc); end
      n_tests++;
      if (bc !== 4) begin n_fail++; $display("FAIL single_busy_cycles: got %0d required 4", bc); end
      n_tests++;
      if (dout !== {4{32'hbca14d8e}}) begin
         n_fail++; $display("FAIL single_result: got %h required %h", dout, {4{32'hbca14d8e}});
      end
      @(negedge clk);
      n_tests++;
      if (bus_if.ready !== 1'b0 || bus_if.output_s !== {4{32'hbca14d8e}}) begin
         n_fail++;
         $display("FAIL ready_one_cycle: ready=%b out=%h required ready=0 out held", bus_if.ready, bus_if.output_s);
      end
   endtask

   task automatic test_mixed();
      logic [127:0] din, dout, exp; int cyc, bc;
      din = {32'h4c31262d, 32'hd5d4d4d4, 32'h01010101, 32'h5c220af2};
      exp = {32'hf8bd7e4d, 32'hd6d7d5d5, 32'h01010101, 32'h9d58dc9f};
      do_block(din, 1'b0, dout, cyc, bc);
      n_tests++;
      if (cyc !== 4 || dout !== exp) begin
         n_fail++; $display("FAIL mixed: got %h (lat %0d) required %h (lat 4)", dout, cyc, exp);
      end
      // same input in bypass must pass through unchanged with identical timing
      do_block(din, 1'b1, dout, cyc, bc);
      n_tests++;
      if (cyc !== 4 || bc !== 4 || dout !== din) begin
         n_fail++; $display("FAIL bypass: got %h (lat %0d busy %0d) required %h (lat 4 busy 4)", dout, cyc, bc, din);
      end
   endtask

   task automatic test_robust();
      logic [127:0] din, exp; int cyc; int extra;
      din = {$urandom, $urandom, $urandom, $urandom};
      exp = model(din, 1'b0);
      @(negedge clk);
      bus_if.start = 1'b1; bus_if.bypass = 1'b0; bus_if.input_s = din;
      @(negedge clk);
      bus_if.start = 1'b0;
      @(negedge clk);
      bus_if.input_s = ~din; bus_if.start = 1'b1; bus_if.bypass = 1'b1;
      @(negedge clk);
      bus_if.start = 1'b0;
      cyc = 2;
      while (!bus_if.ready && cyc < 20) begin @(negedge clk); cyc++; end
      n_tests++;
      if (cyc !== 4 || bus_if.output_s !== exp) begin
         n_fail++; $display("FAIL robust_result: got %h (lat %0d) required %h (lat 4)", bus_if.output_s, cyc, exp);
      end
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus_if.ready || bus_if.busy) extra++;
      end
      n_tests++;
      if (extra !== 0) begin
         n_fail++; $display("FAIL robust_no_extra: %0d busy/ready cycles seen, required 0", extra);
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] d1, d2, dout; int cyc, bc;
      d1 = {$urandom, $urandom, $urandom, $urandom};
      d2 = {$urandom, $urandom, $urandom, $urandom};
      do_block(d1, 1'b0, dout, cyc, bc);
      n_tests++;
      if (dout !== model(d1, 1'b0)) begin
         n_fail++; $display("FAIL b2b_first: got %h required %h", dout, model(d1, 1'b0));
      end
      bus_if.start = 1'b1; bus_if.bypass = 1'b0; bus_if.input_s = d2;
      @(negedge clk);
      bus_if.start = 1'b0;
      n_tests++;
      if (bus_if.ready !== 1'b0 || bus_if.busy !== 1'b1) begin
         n_fail++; $display("FAIL b2b_capture: ready=%b busy=%b required ready=0 busy=1", bus_if.ready, bus_if.busy);
      end
      cyc = 1;
      while (!bus_if.ready && cyc < 20) begin @(negedge clk); cyc++; end
      n_tests++;
      if (cyc !== 5 || bus_if.output_s !== model(d2, 1'b0)) begin
         n_fail++;
         $display("FAIL b2b_second: got %h (spacing %0d) required %h (spacing 5)", bus_if.output_s, cyc, model(d2, 1'b0));
      end
   endtask

   task automatic test_reset_in_run();
      logic [127:0] din, dout; int cyc, bc;
      din = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      bus_if.start = 1'b1; bus_if.bypass = 1'b0; bus_if.input_s = din;
      @(negedge clk);
      bus_if.start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (bus_if.output_s !== 128'h0 || bus_if.busy !== 1'b0 || bus_if.ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_run: out=%h busy=%b ready=%b required all zero", bus_if.output_s, bus_if.busy, bus_if.ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      din = {$urandom, $urandom, $urandom, $urandom};
      do_block(din, 1'b0, dout, cyc, bc);
      n_tests++;
      if (cyc !== 4 || dout !== model(din, 1'b0)) begin
         n_fail++; $display("FAIL after_reset: got %h (lat %0d) required %h (lat 4)", dout, cyc, model(din, 1'b0));
      end
   endtask

   task automatic test_random();
      logic [127:0] din, dout; int cyc, bc; bit byp;
      for (int i = 0; i < 8; i++) begin
         din = {$urandom, $urandom, $urandom, $urandom};
         byp = ($urandom_range(0, 3) == 0);
         do_block(din, byp, dout, cyc, bc);
         n_tests++;
         if (cyc !== 4 || bc !== 4 || dout !== model(din, byp)) begin
            n_fail++;
            $display("FAIL random_%0d: got %h (lat %0d busy %0d) required %h (lat 4 busy 4) bypass=%0d",
                     i, dout, cyc, bc, model(din, byp), byp);
         end
      end
   endtask

   initial begin
      bus_if.start   = 1'b0;
      bus_if.bypass  = 1'b0;
      bus_if.input_s = '0;
      test_reset();
      test_single();
      test_mixed();
      test_robust();
      test_back_to_back();
      test_reset_in_run();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
